// File: rtl/ifid_hazard_ctrl.sv
// IF/ID and PC pipeline control: sequences branch flushes, imem wait states and load-use stalls.
// Define HAZARD_PERF_CNT_EN to add wrapping hazard event counters.
module ifid_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned IMEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        fetch_timeout,
  output logic [1:0]  ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_imem_waits
`endif
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_STALL  = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_IMEM_WAIT = 2'd3
  } state_e;

  // A single-cycle flush needs no FLUSH state: the branch cycle itself flushes IF/ID.
  localparam state_e     BR_STATE     = state_e'((FLUSH_CYCLES > 1) ? 2'd2 : 2'd0);
  localparam logic [2:0] BR_FLUSH_CNT = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_CNT  = 8'(IMEM_TIMEOUT);

  state_e     state_r;
  state_e     state_nxt_s;
  logic [2:0] flush_cnt_r;
  logic [2:0] flush_cnt_nxt_s;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_nxt_s;
  logic       fetch_timeout_r;
  logic       timeout_nxt_s;

  logic       br_s;
  logic       lu_s;
  logic       lu_bubble_s;
  logic       pc_we_s;
  logic       pc_sel_s;
  logic       ifid_we_s;
  logic       ifid_flush_s;
  logic       idex_bubble_s;

  assign br_s = branch_taken & ex_valid;
  assign lu_s = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  // Next-state, counter and pipeline-control decode; branch overrides every state.
  always_comb begin
    pc_we_s         = 1'b0;
    pc_sel_s        = 1'b0;
    ifid_we_s       = 1'b0;
    ifid_flush_s    = 1'b0;
    idex_bubble_s   = 1'b0;
    lu_bubble_s     = 1'b0;
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    if (br_s) begin
      pc_we_s         = 1'b1;
      pc_sel_s        = 1'b1;
      ifid_flush_s    = 1'b1;
      idex_bubble_s   = 1'b1;
      state_nxt_s     = BR_STATE;
      flush_cnt_nxt_s = BR_FLUSH_CNT;
      wait_cnt_nxt_s  = 8'd0;
    end else begin
      case (state_r)
        ST_RUN, ST_LU_STALL: begin
          if (!imem_ready) begin
            ifid_flush_s   = 1'b1;
            state_nxt_s    = ST_IMEM_WAIT;
            wait_cnt_nxt_s = 8'd1;
          end else if ((state_r == ST_RUN) && lu_s) begin
            idex_bubble_s = 1'b1;
            lu_bubble_s   = 1'b1;
            state_nxt_s   = ST_LU_STALL;
          end else begin
            pc_we_s     = 1'b1;
            ifid_we_s   = 1'b1;
            state_nxt_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          ifid_flush_s = 1'b1;
          pc_we_s      = imem_ready;
          if (imem_ready) begin
            if (flush_cnt_r <= 3'd1) begin
              flush_cnt_nxt_s = 3'd0;
              state_nxt_s     = ST_RUN;
            end else begin
              flush_cnt_nxt_s = flush_cnt_r - 3'd1;
            end
          end else begin
            flush_cnt_nxt_s = flush_cnt_r;
          end
        end
        ST_IMEM_WAIT: begin
          if (!imem_ready) begin
            ifid_flush_s = 1'b1;
            if (wait_cnt_r != 8'hFF) begin
              wait_cnt_nxt_s = wait_cnt_r + 8'd1;
            end else begin
              wait_cnt_nxt_s = wait_cnt_r;
            end
          end else begin
            // ID holds a NOP here, so a load-use match is meaningless this cycle.
            pc_we_s        = 1'b1;
            ifid_we_s      = 1'b1;
            wait_cnt_nxt_s = 8'd0;
            state_nxt_s    = ST_RUN;
          end
        end
        default: begin
          ifid_flush_s    = 1'b1;
          idex_bubble_s   = 1'b1;
          state_nxt_s     = ST_RUN;
          flush_cnt_nxt_s = 3'd0;
          wait_cnt_nxt_s  = 8'd0;
        end
      endcase
    end
    // Wait count only reaches values >= 2 by incrementing inside IMEM_WAIT.
    timeout_nxt_s = fetch_timeout_r | (wait_cnt_nxt_s == TIMEOUT_CNT);
  end

  // FSM state, flush/wait counters and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_RUN;
      flush_cnt_r     <= 3'd0;
      wait_cnt_r      <= 8'd0;
      fetch_timeout_r <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      flush_cnt_r     <= flush_cnt_nxt_s;
      wait_cnt_r      <= wait_cnt_nxt_s;
      fetch_timeout_r <= timeout_nxt_s;
    end
  end

  assign pc_we         = rst_n & pc_we_s;
  assign pc_sel        = rst_n & pc_sel_s;
  assign ifid_we       = rst_n & ifid_we_s;
  assign ifid_flush    = ~rst_n | ifid_flush_s;
  assign idex_bubble   = ~rst_n | idex_bubble_s;
  assign fetch_timeout = fetch_timeout_r;
  assign ctrl_state    = state_r;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_r;
  logic [31:0] perf_br_r;
  logic [31:0] perf_wait_r;

  // Wrapping event counters for load-use bubbles, branches and imem wait cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_r   <= 32'd0;
      perf_br_r   <= 32'd0;
      perf_wait_r <= 32'd0;
    end else begin
      perf_lu_r   <= perf_lu_r + {31'd0, lu_bubble_s};
      perf_br_r   <= perf_br_r + {31'd0, br_s};
      perf_wait_r <= perf_wait_r + {31'd0, (state_r == ST_IMEM_WAIT)};
    end
  end

  assign perf_lu_stalls  = perf_lu_r;
  assign perf_flushes    = perf_br_r;
  assign perf_imem_waits = perf_wait_r;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Randomized self-checking bench for ifid_hazard_ctrl against a cycle-level reference model.
module tb_ifid_hazard_ctrl;

  localparam int FC = 3;
  localparam int TO = 64;

  logic       clk;
  logic       rst_n;
  logic       imem_ready;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs2;
  logic       ex_valid;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       branch_taken;
  logic       pc_we;
  logic       pc_sel;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       fetch_timeout;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stalls;
  logic [31:0] perf_flushes;
  logic [31:0] perf_imem_waits;
`endif

  ifid_hazard_ctrl #(.FLUSH_CYCLES(FC), .IMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .pc_we(pc_we), .pc_sel(pc_sel),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fetch_timeout(fetch_timeout), .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_flushes(perf_flushes),
    .perf_imem_waits(perf_imem_waits)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: mode 0 run, 1 one-cycle stall, 2 flushing, 3 waiting on imem.
  int m_mode;
  int m_flush_left;
  int m_wait;
  bit m_to;
  int mp_lu, mp_br, mp_wait;
  logic [4:0] e_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_flush_left = 0; m_wait = 0; m_to = 1'b0;
    mp_lu = 0; mp_br = 0; mp_wait = 0;
  endtask

  // Evaluates outputs for the current inputs and computes the model's next state.
  task automatic model_step(output int n_mode, output int n_fl, output int n_wait, output bit n_to);
    bit br, lu;
    br = branch_taken && ex_valid;
    lu = id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) &&
         ((ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    n_mode = m_mode; n_fl = m_flush_left; n_wait = m_wait; n_to = m_to;
    if (m_mode == 3) mp_wait++;
    if (br) begin
      e_out = 5'b11011;  // {pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble}
      n_mode = (FC > 1) ? 2 : 0;
      n_fl = FC - 1;
      n_wait = 0;
      mp_br++;
    end else if (m_mode <= 1) begin
      if (!imem_ready) begin
        e_out = 5'b00010; n_mode = 3; n_wait = 1;
      end else if (m_mode == 0 && lu) begin
        e_out = 5'b00001; n_mode = 1; mp_lu++;
      end else begin
        e_out = 5'b10100; n_mode = 0;
      end
    end else if (m_mode == 2) begin
      e_out = {imem_ready, 4'b0010};
      if (imem_ready) begin
        n_fl = m_flush_left - 1;
        if (n_fl == 0) n_mode = 0;
      end
    end else begin
      if (!imem_ready) begin
        e_out = 5'b00010;
        n_wait = (m_wait < 255) ? m_wait + 1 : 255;
        if (n_wait == TO) n_to = 1'b1;
      end else begin
        e_out = 5'b10100; n_wait = 0; n_mode = 0;
      end
    end
  endtask

  task automatic step(input logic rdy, input logic bt, input logic exv, input logic exm,
                      input logic idv, input logic u2, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd);
    int n_mode, n_fl, n_wait;
    bit n_to;
    imem_ready = rdy; branch_taken = bt; ex_valid = exv; ex_memread = exm;
    id_valid = idv; id_uses_rs2 = u2; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    #2;
    model_step(n_mode, n_fl, n_wait, n_to);
    check("outs", {27'd0, pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble}, {27'd0, e_out});
    check("state", {30'd0, ctrl_state}, m_mode);
    check("timeout", {31'd0, fetch_timeout}, {31'd0, m_to});
    check("we_vs_flush", {31'd0, ifid_we & ifid_flush}, 32'd0);
    @(posedge clk);
    m_mode = n_mode; m_flush_left = n_fl; m_wait = n_wait; m_to = n_to;
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_outs", {27'd0, pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble}, 32'h3);
    check("rst_state", {30'd0, ctrl_state}, 32'd0);
    check("rst_timeout", {31'd0, fetch_timeout}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input logic rdy);
    step(rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; branch_taken = 1'b0; ex_valid = 1'b0;
    ex_memread = 1'b0; id_valid = 1'b0; id_uses_rs2 = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    model_reset();
    #3;
    check("por_outs", {27'd0, pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble}, 32'h3);
    check("por_state", {30'd0, ctrl_state}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) idle(1'b1);
    // Load-use on rs1, then the same with ex_rd = x0, then via rs2.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd7, 5'd5);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd9, 5'd9);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd9, 5'd9);
    // Branch, then flush cycles with a ready gap inside.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
    idle(1'b1); idle(1'b0); idle(1'b1); idle(1'b1);
    // Branch colliding with load-use and imem not ready.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5);
    idle(1'b1); idle(1'b1); idle(1'b1);
    // Long imem stall crossing the timeout, then recovery.
    for (int i = 0; i < 70; i++) idle(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    // Reset mid-wait and mid-flush.
    for (int i = 0; i < 3; i++) idle(1'b0);
    pulse_reset();
    idle(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    pulse_reset();
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r1, r2, rd;
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) pulse_reset();
      step(($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 85), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) < 85), ($urandom_range(0, 1) == 1), r1, r2, rd);
    end

`ifdef HAZARD_PERF_CNT_EN
    check("perf_lu", perf_lu_stalls, mp_lu);
    check("perf_br", perf_flushes, mp_br);
    check("perf_wait", perf_imem_waits, mp_wait);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
